ram64_frame_reader: RTL and testbench

- Read-side sequencer for the 64x8 dual-port frame RAM. The write side fills the RAM through port C; this block drains a frame from read port A or B.
- On START, reads LEN bytes starting at START_ADDR, wrapping modulo 64, and presents them as a valid/ready byte stream.
- Hides the RAM's one-cycle registered-address read latency behind a 2-entry skid buffer, so output throughput is 1 byte/clock under full TX_READY.

---
 rtl/ram64_pkg.sv | 14 +
 rtl/ram64_frame_reader_if.sv | 29 ++
 rtl/ram64_rd_skid.sv | 53 +++++
 rtl/ram64_frame_reader.sv | 139 +++++++++++++
 tb/tb_ram64_frame_reader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram64_pkg.sv
// Shared constants and FSM state type for the 64x8 frame RAM read sequencer.
package ram64_pkg;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int RAM_DEPTH  = 1 << ADDR_W;
  localparam int LEN_W      = ADDR_W + 1;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/ram64_frame_reader_if.sv
// Control, RAM read port and byte-stream signals of the frame reader.
interface ram64_frame_reader_if #(
  parameter int ADDR_W = ram64_pkg::ADDR_W,
  parameter int DATA_W = ram64_pkg::DATA_W
);
  import ram64_pkg::*;

  logic              START;
  logic [ADDR_W-1:0] START_ADDR;
  logic [ADDR_W:0]   LEN;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_DOUT;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic              TX_LAST;

  modport slave (
    input  START, START_ADDR, LEN, RAM_DOUT, TX_READY,
    output BUSY, DONE, RAM_ADDR, TX_DATA, TX_VALID, TX_LAST
  );

  modport master (
    output START, START_ADDR, LEN, RAM_DOUT, TX_READY,
    input  BUSY, DONE, RAM_ADDR, TX_DATA, TX_VALID, TX_LAST
  );
endinterface

// File: rtl/ram64_rd_skid.sv
// Two-entry FIFO holding RAM read bytes and their end-of-frame flag.
module ram64_rd_skid #(
  parameter int DATA_W = ram64_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last
);
  import ram64_pkg::*;

  logic [DATA_W:0] mem_q [2];
  logic [DATA_W:0] mem_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = {push_last, push_data};
    end
  end

  // Storage carries no reset; occupancy is tracked by the control flops alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];
  assign head_last = mem_q[rd_ptr_q][DATA_W];
endmodule

// File: rtl/ram64_frame_reader.sv
// Drains LEN bytes from the frame RAM starting at START_ADDR (mod 64) onto a
// valid/ready stream, hiding the one-cycle RAM read latency behind a skid FIFO.
module ram64_frame_reader #(
  parameter int ADDR_W     = ram64_pkg::ADDR_W,
  parameter int DATA_W     = ram64_pkg::DATA_W,
  parameter int SKID_DEPTH = ram64_pkg::SKID_DEPTH
) (
  input logic                 CLK,
  input logic                 RST,
  ram64_frame_reader_if.slave bus
);
  import ram64_pkg::*;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(1 << ADDR_W);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic               inflight_q, inflight_d;
  logic               inflight_last_q, inflight_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [1:0]         skid_count;
  logic [DATA_W-1:0]  head_data;
  logic               head_last;
  logic               tx_valid;
  logic               pop;
  logic [2:0]         occ;
  logic               credit;
  logic               issue;
  logic [CNT_W-1:0]   len_eff;

  ram64_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (CLK),
    .rst       (RST),
    .push      (inflight_q),
    .push_data (bus.RAM_DOUT),
    .push_last (inflight_last_q),
    .pop       (pop),
    .count     (skid_count),
    .head_data (head_data),
    .head_last (head_last)
  );

  assign tx_valid = (skid_count != 2'd0);
  assign pop      = tx_valid & bus.TX_READY;
  assign len_eff  = (bus.LEN > MAX_LEN) ? MAX_LEN : bus.LEN;

  // A read may issue only if, after this cycle's pop, buffered plus in-flight
  // bytes still leave room for the byte returning next cycle.
  assign occ    = {1'b0, skid_count} + {2'b0, inflight_q};
  assign credit = occ < (3'(SKID_DEPTH) + {2'b0, pop});
  assign issue  = (state_q == RUN) && credit;

  always_comb begin
    state_d         = state_q;
    ram_addr_d      = ram_addr_q;
    issue_cnt_d     = issue_cnt_q;
    xfer_cnt_d      = xfer_cnt_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    busy_d          = busy_q;
    done_d          = 1'b0;

    if (pop) begin
      xfer_cnt_d = xfer_cnt_q - CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          busy_d = 1'b1;
          if (len_eff == '0) begin
            done_d  = 1'b1;
            state_d = FLUSH;
          end else begin
            ram_addr_d  = bus.START_ADDR;
            issue_cnt_d = len_eff;
            xfer_cnt_d  = len_eff;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          inflight_d      = 1'b1;
          inflight_last_d = (issue_cnt_q == CNT_W'(1));
          ram_addr_d      = ram_addr_q + ADDR_W'(1);
          issue_cnt_d     = issue_cnt_q - CNT_W'(1);
          if (issue_cnt_q == CNT_W'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // done_q marks the DONE cycle; BUSY drops together with it.
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (pop && (xfer_cnt_q == CNT_W'(1))) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      ram_addr_q      <= '0;
      issue_cnt_q     <= '0;
      xfer_cnt_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ram_addr_q      <= ram_addr_d;
      issue_cnt_q     <= issue_cnt_d;
      xfer_cnt_q      <= xfer_cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.RAM_ADDR = ram_addr_q;
  assign bus.TX_VALID = tx_valid;
  assign bus.TX_DATA  = tx_valid ? head_data : '0;
  assign bus.TX_LAST  = tx_valid & head_last;
endmodule

// File: tb/tb_ram64_frame_reader.sv
// Scoreboard bench for ram64_frame_reader with a behavioural 64x8 RAM (mem[i]=i).
`timescale 1ns/1ps
module tb_ram64_frame_reader;
  import ram64_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram64_frame_reader_if bus();

  ram64_frame_reader dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = 8'(i);
  always @(posedge clk) bus.RAM_DOUT <= mem[bus.RAM_ADDR];

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // TX_READY: held high, or cycling 1,0,0,1 when rdy_toggle is set
  logic rdy_toggle = 1'b0;
  int   ph = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_toggle) begin
      bus.TX_READY = (ph == 0 || ph == 3);
      ph = (ph + 1) % 4;
    end else begin
      bus.TX_READY = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stream rules
  logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       prev_done = 1'b0, done_expect = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_done = 1'b0;
      done_expect = 1'b0;
    end else begin
      if (done_expect) begin
        chk("done_after_last", 32'(bus.DONE), 32'd1);
        done_expect = 1'b0;
      end
      if (prev_done) chk("busy_done_fall", 32'({bus.BUSY, bus.DONE}), 32'd0);
      prev_done = bus.DONE;
      if (bus.DONE) done_cnt++;
      if (prev_v && !prev_r)
        chk("stall_hold", 32'({bus.TX_VALID, bus.TX_LAST, bus.TX_DATA}), 32'({1'b1, prev_l, prev_d}));
      if (bus.TX_VALID && bus.TX_READY) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_byte: got 0x%0h required no byte", bus.TX_DATA);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tx_data", 32'(bus.TX_DATA), 32'(e.data));
          chk("tx_last", 32'(bus.TX_LAST), 32'(e.last));
          if (e.last) done_expect = 1'b1;
        end
      end
      prev_v = bus.TX_VALID;
      prev_r = bus.TX_READY;
      prev_d = bus.TX_DATA;
      prev_l = bus.TX_LAST;
    end
  end

  task automatic push_exp(input int addr, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = 8'((addr + i) % 64);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Returns 2 time units after the START-accepting edge
  task automatic start_frame(input int addr, input int len);
    @(posedge clk);
    #2;
    bus.START      = 1'b1;
    bus.START_ADDR = 6'(addr);
    bus.LEN        = 7'(len);
    @(posedge clk);
    #2;
    bus.START = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int done_base);
    int t;
    t = 0;
    while (bus.BUSY && t < 500) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk({name, "_timeout"}, 32'(t >= 500), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  initial begin
    int base;
    int lat;
    int t;
    int hs_base;
    bus.START      = 1'b0;
    bus.START_ADDR = '0;
    bus.LEN        = '0;

    #3;
    chk("reset_stream", 32'({bus.TX_VALID, bus.TX_LAST, bus.TX_DATA}), 32'd0);
    chk("reset_ctrl", 32'({bus.BUSY, bus.DONE}), 32'd0);
    chk("reset_ram_addr", 32'(bus.RAM_ADDR), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // 4 bytes from address 0, full throughput
    base = done_cnt;
    push_exp(0, 4);
    start_frame(0, 4);
    lat = 0;
    while (!bus.TX_VALID && lat < 20) begin
      @(posedge clk);
      #2;
      lat++;
    end
    chk("first_valid_latency", 32'(lat), 32'd2);
    wait_frame("len4", base);

    // wrap across address 63 -> 0
    base = done_cnt;
    push_exp(62, 4);
    start_frame(62, 4);
    chk("ram_addr_0", 32'(bus.RAM_ADDR), 32'd62);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #2;
      chk("ram_addr_seq", 32'(bus.RAM_ADDR), 32'((62 + i) % 64));
    end
    wait_frame("wrap", base);

    // full frame under 1,0,0,1 backpressure
    base = done_cnt;
    rdy_toggle = 1'b1;
    push_exp(0, 64);
    start_frame(0, 64);
    wait_frame("len64_bp", base);
    rdy_toggle = 1'b0;

    // zero-length frame
    base = done_cnt;
    start_frame(7, 0);
    chk("len0_pulse", 32'({bus.BUSY, bus.DONE, bus.TX_VALID}), 32'b110);
    @(posedge clk);
    #2;
    chk("len0_after", 32'({bus.BUSY, bus.DONE, bus.TX_VALID}), 32'b000);
    wait_frame("len0", base);

    // oversize length clips to 64
    base = done_cnt;
    push_exp(10, 64);
    start_frame(10, 100);
    wait_frame("len100", base);

    // second START mid-frame is ignored
    base = done_cnt;
    push_exp(20, 8);
    start_frame(20, 8);
    repeat (2) @(posedge clk);
    #2;
    bus.START      = 1'b1;
    bus.START_ADDR = 6'd40;
    bus.LEN        = 7'd5;
    @(posedge clk);
    #2;
    bus.START = 1'b0;
    wait_frame("restart_ignored", base);

    // reset after the third byte of a 10-byte frame
    base    = done_cnt;
    hs_base = hs_cnt;
    push_exp(0, 10);
    start_frame(0, 10);
    t = 0;
    while ((hs_cnt - hs_base) < 3 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("rst_wait_timeout", 32'(t >= 100), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_stream", 32'({bus.TX_VALID, bus.TX_LAST, bus.TX_DATA}), 32'd0);
    chk("rst_async_ctrl", 32'({bus.BUSY, bus.DONE, bus.RAM_ADDR}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_no_done", 32'(done_cnt - base), 32'd0);
    base = done_cnt;
    push_exp(5, 2);
    start_frame(5, 2);
    wait_frame("after_rst", base);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
